switch_debounce_multi: RTL
==========================

Name: switch_debounce_multi

Overview:
Multi-channel, parametrised debouncer for toggle switches and push-buttons feeding the processor's I/O front end. Each channel provides:
- a multi-flop input synchroniser;
- a per-channel stability counter with a programmable limit;
- an optional sample-tick prescaler input.

Outputs are the debounced level plus one-cycle rise/fall pulses per channel and a global change flag for the I/O interrupt logic.

Parameters:
CHANNELS, 8, number of independent switch inputs (>=1)
CNT_W, 16, width of each stability counter
LIMIT, 16'hFFFF, accepted ticks of stable mismatch before the output flips (1..2^CNT_W-1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
RESET_STATE, 1'b0, value of sync flops and out_state after reset (all channels)

Ports:
iclk  input  1  system clock, rising edge
irst_n  input  1  asynchronous active-low reset
itick  input  1  sample enable; counters advance only when high (tie 1 for per-clock counting)
in_bit  input  CHANNELS  raw switch inputs, asynchronous to iclk
out_state  output  CHANNELS  debounced level, registered
rise_pulse  output  CHANNELS  one-cycle pulse, same cycle out_state goes 0->1
fall_pulse  output  CHANNELS  one-cycle pulse, same cycle out_state goes 1->0
any_change  output  1  registered OR of rise_pulse|fall_pulse (one cycle later)

Behaviour:
- Reset: irst_n low asynchronously clears the following. Deassertion is synchronised externally.
  - all sync flops = RESET_STATE;
  - out_state = {CHANNELS{RESET_STATE}};
  - counters = 0;
  - rise_pulse = fall_pulse = 0;
  - any_change = 0.
- Synchroniser: SYNC_STAGES-deep shift per channel. sync_q is the last stage. Raw in_bit is never used elsewhere.
- Per channel, each rising iclk:
  - sync_q == out_state: counter <= 0 regardless of itick. Any bounce back restarts the count.
  - sync_q != out_state and itick=0: counter holds.
  - sync_q != out_state, itick=1, counter != LIMIT: counter <= counter+1.
  - sync_q != out_state, itick=1, counter == LIMIT: out_state <= ~out_state, counter <= 0, matching pulse asserted this same edge.
- Counter never exceeds LIMIT and never wraps. Width rule: LIMIT compared at CNT_W bits; elaboration error if LIMIT==0 or LIMIT>=2^CNT_W.
- Pulses: rise_pulse/fall_pulse high exactly one cycle, coincident with the out_state transition. Never both high on one channel.
- any_change: rise|fall OR-reduced and registered, so it is asserted the cycle after the pulse(s).
- Latency, itick=1: input change sampled at edge 1 -> out_state changes at edge SYNC_STAGES+LIMIT+1.
  - With itick a period-P strobe, the count phase is scaled by P; the toggle occurs on the (LIMIT+1)-th tick after mismatch begins.
- Channels fully independent. Simultaneous toggles on several channels are allowed; any_change is a single 1.
- Reset mid-count: count lost, out_state returns to RESET_STATE. A pending input mismatch restarts counting from 0 after release.
- out_state only ever changes via the LIMIT path; no bypass mode.

Decomposition:
- Package switch_debounce_pkg:
  - default constants DEBOUNCE_CNT_W=16, DEBOUNCE_LIMIT=16'hFFFF, DEBOUNCE_SYNC=2;
  - helper function checking LIMIT range.
- Sub-module debounce_channel (one synchroniser + counter + pulse logic), generate-instantiated CHANNELS times.
- The top holds only the generate loop and the any_change register.

Test Plan:
- Reset: irst_n=0 with in_bit=8'hFF, RESET_STATE=0 -> out_state=8'h00, no pulses. Release, hold in_bit=8'hFF, LIMIT=4, SYNC=2, itick=1 -> out_state=8'hFF at edge 7, rise_pulse=8'hFF for exactly 1 cycle, any_change=1 at edge 8.
- Bounce: ch0 goes 0->1, returns to 0 after 3 cycles, then 1 stable (LIMIT=4) -> no toggle during bounce; toggle 7 edges after last 0->1 sample; single rise_pulse.
- Prescale: itick high every 4th cycle, LIMIT=4, ch3 1->0 -> counter advances only on tick cycles; fall_pulse[3] on the 5th tick after mismatch visible at sync_q; out_state[3] stable until then.
- Mixed simultaneous: ch1 rises, ch2 falls on the same cycle, both stable -> rise_pulse=8'h02 and fall_pulse=8'h04 on the same edge; any_change a single-cycle 1.
- Reset mid-count: ch5 mismatch counted to 3 of LIMIT=4, assert irst_n asynchronously between edges -> out_state[5]=0 and counter 0 immediately. After release, full SYNC+LIMIT+1 latency again.
- Max limit: CNT_W=16, LIMIT=16'hFFFF, stable change -> toggle after 2+65535+1 edges, counter never wraps to 0 before the toggle.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared defaults and parameter checks for the multi-channel switch debouncer.
package switch_debounce_pkg;

   localparam int              DEBOUNCE_CNT_W = 16;
   localparam longint unsigned DEBOUNCE_LIMIT = 64'h0000_0000_0000_FFFF;
   localparam int              DEBOUNCE_SYNC  = 2;

   // True when limit is non-zero and representable in a cnt_w-bit counter.
   function automatic bit limit_in_range(input int cnt_w, input longint unsigned limit);
      bit ok;
      ok = (limit != 64'd0);
      if (cnt_w < 64) begin
         ok = ok && (limit < (64'd1 << cnt_w));
      end
      return ok;
   endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One debounce lane: input synchroniser, stability counter and edge pulses.
module debounce_channel
   import switch_debounce_pkg::*;
#(
   parameter int              CNT_W       = DEBOUNCE_CNT_W,
   parameter longint unsigned LIMIT       = DEBOUNCE_LIMIT,
   parameter int              SYNC_STAGES = DEBOUNCE_SYNC,
   parameter logic            RESET_STATE = 1'b0
) (
   input  logic iclk,
   input  logic irst_n,
   input  logic itick,
   input  logic in_bit,
   output logic out_state,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   if (!limit_in_range(CNT_W, LIMIT)) begin : g_bad_limit
      $error("debounce_channel: LIMIT must be in 1..2**CNT_W-1");
   end

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_channel: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_sr;
   logic                   sync_q;
   logic [CNT_W-1:0]       cnt;

   assign sync_q = sync_sr[SYNC_STAGES-1];

   // Synchroniser: shift the raw asynchronous input through SYNC_STAGES flops.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         sync_sr <= {SYNC_STAGES{RESET_STATE}};
      end else begin
         sync_sr <= {sync_sr[SYNC_STAGES-2:0], in_bit};
      end
   end

   // Stability counter: any agreement restarts it; flip the level after LIMIT+1 mismatched ticks.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         cnt        <= '0;
         out_state  <= RESET_STATE;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         if (sync_q == out_state) begin
            cnt <= '0;
         end else if (itick) begin
            if (cnt == LIMIT_C) begin
               out_state  <= ~out_state;
               cnt        <= '0;
               rise_pulse <= ~out_state;
               fall_pulse <= out_state;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/switch_debounce_multi.sv
// Multi-channel switch debouncer: independent lanes plus a global change flag.
module switch_debounce_multi
   import switch_debounce_pkg::*;
#(
   parameter int              CHANNELS    = 8,
   parameter int              CNT_W       = DEBOUNCE_CNT_W,
   parameter longint unsigned LIMIT       = DEBOUNCE_LIMIT,
   parameter int              SYNC_STAGES = DEBOUNCE_SYNC,
   parameter logic            RESET_STATE = 1'b0
) (
   input  logic                iclk,
   input  logic                irst_n,
   input  logic                itick,
   input  logic [CHANNELS-1:0] in_bit,
   output logic [CHANNELS-1:0] out_state,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic                any_change
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .CNT_W       (CNT_W),
         .LIMIT       (LIMIT),
         .SYNC_STAGES (SYNC_STAGES),
         .RESET_STATE (RESET_STATE)
      ) u_ch (
         .iclk       (iclk),
         .irst_n     (irst_n),
         .itick      (itick),
         .in_bit     (in_bit[g]),
         .out_state  (out_state[g]),
         .rise_pulse (rise_pulse[g]),
         .fall_pulse (fall_pulse[g])
      );
   end

   // Interrupt flag: registered OR of every lane's pulses, one cycle behind them.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         any_change <= 1'b0;
      end else begin
         any_change <= |(rise_pulse | fall_pulse);
      end
   end

endmodule
